writeback_arbiter: RTL

- Final pipeline stage directly upstream of the register file.
- Merges results from two producers into the register file's single write port (we, rd, d_in): the single-cycle ALU and the variable-latency load/store unit (LSU).
- The ALU has priority. LSU results are queued in a small FIFO so that none are lost.
- Guarantees at most one register write per cycle and never requests a write to x0.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 68 ++++++
 rtl/writeback_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide constants and types.
//   REG_SIZE   - width of one architectural register / result
//   REG_NUM    - number of architectural registers
//   REG_IDX_W  - width of a register index
//   reg_idx_t  - register index type
//   wb_req_t   - one register-file write request (destination + value)
//   wb_grant_t - which source owns the write port in a given cycle
package cpu_pkg;

  localparam int REG_SIZE  = 32;
  localparam int REG_NUM   = 16;
  localparam int REG_IDX_W = $clog2(REG_NUM);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            rd;
    logic [REG_SIZE-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_ALU   = 2'd1,
    GRANT_DRAIN = 2'd2,
    GRANT_FULL  = 2'd3
  } wb_grant_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t used to queue LSU results.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset (pointers/count only)
//   push, push_data    - enqueue one entry (caller guarantees !full)
//   pop                - dequeue the head (caller guarantees !empty)
//   head               - current head entry, valid whenever !empty
//   full, empty, count - occupancy status, derived from registered count
// FIFO_DEPTH must be a power of two so pointers wrap by plain truncation.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Simultaneous push and pop leave the count unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and LSU results onto the single register-file
// write port. ALU has priority; LSU results wait in wb_fifo. A full queue
// stalls the ALU for one cycle so the queue head always drains eventually.
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data - single-cycle ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data - LSU load result handshake
//   wb_we/wb_rd/wb_data                 - registered register-file write port
//   fifo_count                          - queued LSU results
//   wb_busy                             - high while any LSU result is queued
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [REG_SIZE-1:0]  alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [REG_SIZE-1:0]  mem_data,
  output logic                 wb_we,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [REG_SIZE-1:0]  wb_data,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 wb_busy
);

  wb_grant_t            grant;
  wb_req_t              fifo_head;
  wb_req_t              fifo_push_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;

  logic                 wb_we_q,   wb_we_d;
  logic [REG_IDX_W-1:0] wb_rd_q,   wb_rd_d;
  logic [REG_SIZE-1:0]  wb_data_q, wb_data_d;

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Grant selection. Uses the registered occupancy only, so an entry pushed
  // this cycle cannot be popped until the next one (no mem_* -> wb_* path).
  always_comb begin
    grant = GRANT_IDLE;
    if (fifo_full)        grant = GRANT_FULL;
    else if (alu_valid)   grant = GRANT_ALU;
    else if (!fifo_empty) grant = GRANT_DRAIN;
  end

  // Handshakes, queue control and next write-port values.
  always_comb begin
    alu_ready           = rst_n && !fifo_full;
    mem_ready           = rst_n && !fifo_full;
    // Loads to x0 are accepted but never queued.
    fifo_push           = mem_valid && mem_ready && (mem_rd != '0);
    fifo_push_data.rd   = mem_rd;
    fifo_push_data.data = mem_data;
    fifo_pop            = 1'b0;
    wb_we_d             = 1'b0;
    wb_rd_d             = wb_rd_q;
    wb_data_d           = wb_data_q;
    case (grant)
      GRANT_FULL, GRANT_DRAIN: begin
        fifo_pop  = rst_n;
        wb_we_d   = 1'b1;
        wb_rd_d   = fifo_head.rd;
        wb_data_d = fifo_head.data;
      end
      GRANT_ALU: begin
        wb_we_d   = (alu_rd != '0);
        wb_rd_d   = alu_rd;
        wb_data_d = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign wb_busy = (fifo_count != '0);

endmodule
